// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the data-memory interface. Accepts one load/store request
//   at a time over a valid/ready request channel and answers over a valid/ready
//   response channel after LATENCY cycles. Backed by a DEPTH x 64-bit
//   little-endian RAM supporting byte/half/word/dword accesses with sign- or
//   zero-extension of loads.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     undefined : addresses are force-aligned to the access size, resp_err = 0
//     defined   : misaligned accesses leave RAM untouched and return
//                 resp_rdata = 0, resp_err = 1 with normal timing
//
// Parameters
//   DEPTH        number of 64-bit words (power of two)
//   LATENCY      cycles from request accept to resp_valid (1..15)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    request present             req_ready   can accept a request
//   req_we       1 = store, 0 = load         req_addr    byte address
//   req_size     0 byte,1 half,2 word,3 dword
//   req_unsigned load zero-extends when 1    req_wdata   right-aligned store data
//   resp_valid   response present            resp_ready  requester takes response
//   resp_rdata   extended load data (0 for stores)
//   resp_err     misalignment error (0 unless MISALIGN_TRAP_EN)
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [2:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;

    logic [63:0]     mem [DEPTH];

    logic [2:0]      align_mask;
    logic [2:0]      lane_eff;
    logic [7:0]      size_bytes;
    logic [7:0]      be;
    logic [63:0]     bitmask;
    logic [63:0]     word;
    logic [63:0]     shifted;
    logic [63:0]     ext;
    logic [63:0]     merged;
    logic            access;
    logic            commit;
    logic            drop;

    // Upper address bits wrap the RAM and are intentionally ignored.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^req_addr[63:AW+3];

    // ---------------- datapath: lane selection, merge and extension ----------
    always_comb begin
        unique case (size_q)
            2'd0:    begin align_mask = 3'b111; size_bytes = 8'h01; end
            2'd1:    begin align_mask = 3'b110; size_bytes = 8'h03; end
            2'd2:    begin align_mask = 3'b100; size_bytes = 8'h0F; end
            default: begin align_mask = 3'b000; size_bytes = 8'hFF; end
        endcase
        lane_eff = lane_q & align_mask;
        be       = size_bytes << lane_eff;
        for (int unsigned i = 0; i < 8; i++) begin
            bitmask[8*i +: 8] = {8{be[i]}};
        end
        word    = mem[idx_q];
        shifted = word >> {lane_eff, 3'b000};
        merged  = (word & ~bitmask) | ((wdata_q << {lane_eff, 3'b000}) & bitmask);
        unique case (size_q)
            2'd0:    ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    assign drop     = |(lane_q & ~align_mask);
    assign resp_err = err_q;
`else
    assign drop     = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Access happens on the last WAIT cycle, together with the move to RESP.
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);
    assign commit = access && we_q && !drop;

    // ---------------- FSM next-state / capture logic -------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[AW+2:3];
                    lane_d  = req_addr[2:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (we_q || drop) ? '0 : ext;
`ifdef MISALIGN_TRAP_EN
                    err_d   = drop;
`endif
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAM is not reset; reset forces IDLE so an in-flight store never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= merged;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;

endmodule
